// File: rtl/arm_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
package arm_pkg;

    localparam int REG_W = 4;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Per-slot comparator: flags a read of an in-flight destination register.
module sb_match
    import arm_pkg::*;
(
    input  sb_entry_t              entry,
    input  logic [REG_W-1:0]       src_1,
    input  logic                   src1_used,
    input  logic [REG_W-1:0]       src_2,
    input  logic                   two_src,
    output logic                   hit
);

    assign hit = entry.valid &&
                 ((src1_used && (src_1 == entry.dest)) ||
                  (two_src   && (src_2 == entry.dest)));

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks EXE/MEM destinations and raises a stall for the decode stage.
// Build option FORWARDING_EN: stall on load-use only and expose per-slot fwd_hit.
module hazard_scoreboard
    import arm_pkg::sb_entry_t;
#(
    parameter int DEPTH = arm_pkg::DEPTH,
    parameter int REG_W = arm_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic [REG_W-1:0] src_1,
    input  logic             src1_used,
    input  logic [REG_W-1:0] src_2,
    input  logic             two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    output logic             hazard,
    output logic [DEPTH-1:0] sb_valid,
    output logic [CNT_W-1:0] stall_cnt
`ifdef FORWARDING_EN
    ,
    output logic [DEPTH-1:0] fwd_hit
`endif
);

    sb_entry_t        slots [DEPTH];
    logic [DEPTH-1:0] hits;
    logic             hazard_raw;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        sb_match u_match (
            .entry     (slots[g]),
            .src_1     (src_1),
            .src1_used (src1_used),
            .src_2     (src_2),
            .two_src   (two_src),
            .hit       (hits[g])
        );
    end

`ifdef FORWARDING_EN
    // Only a load still in EXE cannot be forwarded in time.
    assign hazard_raw = hits[0] && slots[0].is_load;
    assign fwd_hit    = hits;
`else
    assign hazard_raw = |hits;
`endif

    // A squashed ID instruction never needs to stall.
    assign hazard = hazard_raw && !flush;

    always_comb begin
        sb_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sb_valid[i] = slots[i].valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (!freeze) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slots[i] <= slots[i-1];
            end
            slots[0].valid   <= id_wb_en && !hazard && !flush;
            slots[0].dest    <= id_dest;
            slots[0].is_load <= id_mem_r_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && !freeze && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Queue-based scoreboard bench for hazard_scoreboard (DEPTH=2, CNT_W=4).
module tb_hazard_scoreboard;

    typedef struct {
        string      name;
        logic       hz;
        logic [1:0] v;
        logic [3:0] cnt;
        logic [1:0] fwd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       freeze = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] src_1 = '0;
    logic       src1_used = 1'b0;
    logic [3:0] src_2 = '0;
    logic       two_src = 1'b0;
    logic       id_wb_en = 1'b0;
    logic       id_mem_r_en = 1'b0;
    logic [3:0] id_dest = '0;
    logic       hazard;
    logic [1:0] sb_valid;
    logic [3:0] stall_cnt;
`ifdef FORWARDING_EN
    logic [1:0] fwd_hit;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    hazard_scoreboard #(.DEPTH(2), .REG_W(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .src_1       (src_1),
        .src1_used   (src1_used),
        .src_2       (src_2),
        .two_src     (two_src),
        .id_wb_en    (id_wb_en),
        .id_mem_r_en (id_mem_r_en),
        .id_dest     (id_dest),
        .hazard      (hazard),
        .sb_valid    (sb_valid),
        .stall_cnt   (stall_cnt)
`ifdef FORWARDING_EN
        ,
        .fwd_hit     (fwd_hit)
`endif
    );

    always #5 clk = ~clk;

    // One cycle of stimulus, applied just after the rising edge, with its expectation queued.
    task automatic cyc(input string nm, input logic r, input logic w, input logic [3:0] d,
                       input logic ld, input logic u1, input logic [3:0] s1, input logic t2,
                       input logic [3:0] s2, input logic fl, input logic fz, input logic ehz,
                       input logic [1:0] ev, input logic [3:0] ec, input logic [1:0] ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_wb_en = w; id_dest = d; id_mem_r_en = ld;
        src1_used = u1; src_1 = s1; two_src = t2; src_2 = s2;
        flush = fl; freeze = fz;
        e.name = nm; e.hz = ehz; e.v = ev; e.cnt = ec; e.fwd = ef;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            checks++;
            bad = (hazard !== e.hz) || (sb_valid !== e.v) || (stall_cnt !== e.cnt);
`ifdef FORWARDING_EN
            bad = bad || (fwd_hit !== e.fwd);
            if (bad)
                $display("FAIL %s: got hazard=%0b sb_valid=%b stall_cnt=%0d fwd_hit=%b, want hazard=%0b sb_valid=%b stall_cnt=%0d fwd_hit=%b",
                         e.name, hazard, sb_valid, stall_cnt, fwd_hit, e.hz, e.v, e.cnt, e.fwd);
`else
            if (bad)
                $display("FAIL %s: got hazard=%0b sb_valid=%b stall_cnt=%0d, want hazard=%0b sb_valid=%b stall_cnt=%0d",
                         e.name, hazard, sb_valid, stall_cnt, e.hz, e.v, e.cnt);
`endif
            if (bad) failures++;
        end
    end

    initial begin
        //   name           r  w  d   ld u1 s1  t2 s2  fl fz  hz  v      cnt  fwd
        cyc("reset",        1, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 0, 2'b00);
`ifndef FORWARDING_EN
        cyc("raw_issue",    0, 1, 3,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 0, 2'b00);
        cyc("raw_stall1",   0, 1, 8,  0, 1, 3,  0, 0,  0, 0,  1, 2'b01, 0, 2'b00);
        cyc("raw_stall2",   0, 1, 8,  0, 1, 3,  0, 0,  0, 0,  1, 2'b10, 1, 2'b00);
        cyc("raw_go",       0, 1, 8,  0, 1, 3,  0, 0,  0, 0,  0, 2'b00, 2, 2'b00);
        cyc("raw_drain1",   0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b01, 2, 2'b00);
        cyc("raw_drain2",   0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b10, 2, 2'b00);
        cyc("st_issue",     0, 1, 5,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 2, 2'b00);
        cyc("st_two_src",   0, 0, 0,  0, 0, 5,  1, 5,  0, 0,  1, 2'b01, 2, 2'b00);
        cyc("st_one_src",   0, 0, 0,  0, 0, 5,  0, 5,  0, 0,  0, 2'b10, 3, 2'b00);
        cyc("fl_issue",     0, 1, 7,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 3, 2'b00);
        cyc("fl_flush",     0, 1, 9,  0, 1, 7,  0, 0,  1, 0,  0, 2'b01, 3, 2'b00);
        cyc("fl_bubble",    0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b10, 3, 2'b00);
        cyc("fz_issue",     0, 1, 2,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 3, 2'b00);
        for (int k = 0; k < 4; k++)
            cyc("fz_hold",  0, 0, 0,  0, 1, 2,  0, 0,  0, 1,  1, 2'b01, 3, 2'b00);
        cyc("fz_release",   0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b01, 3, 2'b00);
        cyc("fz_retire1",   0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b10, 3, 2'b00);
        cyc("fz_retire2",   0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 3, 2'b00);
        cyc("ff_issue",     0, 1, 6,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 3, 2'b00);
        cyc("ff_both",      0, 1, 1,  0, 1, 6,  0, 0,  1, 1,  0, 2'b01, 3, 2'b00);
        cyc("ff_held",      0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b01, 3, 2'b00);
        cyc("ff_drain",     0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b10, 3, 2'b00);
        cyc("pc_issue",     0, 1, 15, 0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 3, 2'b00);
        cyc("pc_hazard",    0, 0, 0,  0, 0, 0,  1, 15, 0, 0,  1, 2'b01, 3, 2'b00);
        cyc("pc_clear",     0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b10, 4, 2'b00);
        begin
            logic [3:0] ec;
            ec = 4;
            // Ten producer/consumer rounds give 20 stall cycles; 4 + 20 saturates at 15.
            for (int k = 0; k < 10; k++) begin
                cyc("sat_prod", 0, 1, 1,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, ec, 2'b00);
                cyc("sat_h1",   0, 0, 0,  0, 1, 1,  0, 0,  0, 0,  1, 2'b01, ec, 2'b00);
                if (ec != 4'hf) ec = ec + 1;
                cyc("sat_h2",   0, 0, 0,  0, 1, 1,  0, 0,  0, 0,  1, 2'b10, ec, 2'b00);
                if (ec != 4'hf) ec = ec + 1;
            end
        end
        cyc("rst_prod",     0, 1, 3,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 15, 2'b00);
        cyc("rst_pre",      0, 0, 0,  0, 1, 3,  0, 0,  0, 0,  1, 2'b01, 15, 2'b00);
        cyc("rst_mid",      1, 0, 0,  0, 1, 3,  0, 0,  0, 0,  0, 2'b00, 0, 2'b00);
        cyc("rst_after",    0, 0, 0,  0, 1, 3,  0, 0,  0, 0,  0, 2'b00, 0, 2'b00);
`else
        cyc("fw_alu",       0, 1, 4,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 0, 2'b00);
        cyc("fw_alu_use",   0, 1, 5,  0, 1, 4,  0, 0,  0, 0,  0, 2'b01, 0, 2'b01);
        cyc("fw_idle1",     0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b11, 0, 2'b00);
        cyc("fw_load",      0, 1, 4,  1, 0, 0,  0, 0,  0, 0,  0, 2'b10, 0, 2'b00);
        cyc("fw_ld_use",    0, 1, 6,  0, 1, 4,  0, 0,  0, 0,  1, 2'b01, 0, 2'b01);
        cyc("fw_ld_fwd",    0, 1, 6,  0, 1, 4,  0, 0,  0, 0,  0, 2'b10, 1, 2'b10);
        cyc("fw_idle2",     0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b01, 1, 2'b00);
        cyc("fw_mem_src2",  0, 0, 0,  0, 0, 0,  1, 6,  0, 0,  0, 2'b10, 1, 2'b10);
        cyc("fw_idle3",     0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b00, 1, 2'b00);
        cyc("fw_load2",     0, 1, 2,  1, 0, 0,  0, 0,  0, 0,  0, 2'b00, 1, 2'b00);
        cyc("fw_flush",     0, 1, 9,  0, 0, 0,  1, 2,  1, 0,  0, 2'b01, 1, 2'b01);
        cyc("fw_bubble",    0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 2'b10, 1, 2'b00);
`endif
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
            failures += exp_q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Scoreboard-based hazard controller feeding the `hazard` input of the decode stage.
- Tracks destination registers of instructions in flight in EXE and MEM.
- Compares them against the decode stage's source registers and raises `hazard` to stall IF/ID and bubble ID's control outputs.
- Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- DEPTH, 2, number of in-flight pipeline slots tracked (slot 0 = EXE, slot DEPTH-1 = oldest).
- REG_W, 4, register index width.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- freeze  in  1  global pipeline freeze (memory wait); scoreboard holds.
- flush  in  1  branch taken in EXE; instruction currently in ID is discarded.
- src_1  in  REG_W  Rn index from decode.
- src1_used  in  1  decode instruction reads Rn.
- src_2  in  REG_W  second source index (Rm, or Rd for stores).
- two_src  in  1  decode instruction reads src_2.
- id_wb_en  in  1  raw (pre-bubble) writeback enable of the decode instruction.
- id_mem_r_en  in  1  raw load flag of the decode instruction.
- id_dest  in  REG_W  destination register of the decode instruction.
- hazard  out  1  combinational stall request to IF/ID.
- sb_valid  out  DEPTH  per-slot valid bits (debug).
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Each slot holds {valid, dest, is_load}.
- Reset (async, rst=1): all slots invalid, stall_cnt=0, sb_valid=0; hazard=0 since no slot is valid.
- Match in slot i: valid_i && ((src1_used && src_1==dest_i) || (two_src && src_2==dest_i)).
- hazard (no forwarding): OR of matches over all slots, combinational, same cycle as the inputs.
- hazard is forced 0 when flush=1, because the ID instruction is being squashed.
- Update on rising clk when freeze=0:
  - slots shift (slot i+1 <= slot i; oldest entry retires);
  - slot 0 <= {id_wb_en && !hazard && !flush, id_dest, id_mem_r_en}.
  - A stalled or flushed instruction therefore enters as a bubble (valid=0).
- freeze=1: all slots hold. hazard is still evaluated combinationally.
- stall_cnt increments on clk when hazard && !freeze, and saturates at all-ones (no wrap).
- Simultaneous flush and hazard inputs: flush wins, hazard=0, a bubble is pushed.
- Simultaneous freeze and flush: freeze wins; state holds and flush has no scoreboard effect that cycle.
- Reset mid-operation: slots cleared immediately; hazard drops in the same cycle.
- Register index 15 (PC) is treated like any other index; no special case.
- Latency: one cycle from ID issue to visibility in slot 0. An entry stays visible for DEPTH non-frozen cycles.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - hazard is raised only when slot 0 matches with is_load=1 (load-use); all other matches are resolved by the forwarding unit.
  - Additional output port fwd_hit[DEPTH-1:0] gives per-slot match bits for the forwarding mux.
- Undefined: full-stall behaviour as above; fwd_hit port absent.

Decomposition:
- Shared package arm_pkg:
  - REG_W constant;
  - sb_entry_t struct {valid, dest[REG_W-1:0], is_load};
  - DEPTH default constant.
- One natural sub-module: sb_match, a per-slot comparator (entry, src_1, src1_used, src_2, two_src -> hit), instantiated DEPTH times via generate.

Test Plan:
- RAW, back-to-back: cycle 0 issue wb_en=1 dest=3; cycle 1 src_1=3, src1_used=1.
  - Expected: hazard=1 in cycles 1 and 2, 0 in cycle 3; stall_cnt=2.
- Two-source store: slot holds dest=5; decode two_src=1, src_2=5, src1_used=0 -> hazard=1. Same with two_src=0 -> hazard=0.
- Flush priority: slot 0 dest=7; decode src_1=7 with flush=1 -> hazard=0; next cycle sb_valid[0]=0.
- Freeze hold: dest=2 in slot 0; freeze=1 for 4 cycles, decode src_1=2.
  - Expected: hazard=1 throughout, sb_valid unchanged, stall_cnt unchanged.
  - After release, entry retires after 2 more cycles.
- Saturation and reset: with CNT_W=4, force 20 hazard cycles -> stall_cnt=15.
  - Assert rst mid-cycle -> stall_cnt=0, sb_valid=0, hazard=0 immediately.
- FORWARDING_EN: ALU op dest=4, then consumer src_1=4 -> hazard=0, fwd_hit=01.
  - Load dest=4, then consumer src_1=4 -> hazard=1 for exactly one cycle.
